// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: valid/ready handshake, 2-entry skid buffer,
// flush that injects BUBBLE. Define PIPE_STAGE_PERF_EN for stall/kill counters.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W = 32,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush
`ifdef PIPE_STAGE_PERF_EN
    , output logic [CNT_W-1:0] stall_cnt
    , output logic [CNT_W-1:0] kill_cnt
`endif
);

    // Parameter range guard, present in every build.
    if (DATA_W < 1 || DATA_W > 512) begin : g_bad_data_w
        $error("pipe_stage_reg: DATA_W out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W must be at least 1");
    end

    // Encoding puts out_valid in bit 1 and in_ready in bit 0, so both are plain flop outputs.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b01,
        ST_FULL  = 2'b11,
        ST_SKID  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d = ST_FULL;
                        main_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (in_valid) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so in_valid is deliberately ignored.
                    if (out_ready) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    assign out_valid = state_q[1];
    assign in_ready  = state_q[0];
    assign out_data  = main_q;

`ifdef PIPE_STAGE_PERF_EN
    localparam int unsigned SUM_W = CNT_W + 1;

    logic             stall_ev;
    logic             main_kill;
    logic [1:0]       kill_inc;
    logic [SUM_W-1:0] kill_sum;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] kill_q, kill_d;

    assign stall_ev  = out_valid & ~out_ready;
    // Main is only lost to a flush if downstream does not take it the same cycle.
    assign main_kill = flush & out_valid & ~out_ready;
    assign kill_inc  = 2'(main_kill) + 2'(flush && (state_q == ST_SKID));
    assign kill_sum  = SUM_W'(kill_q) + SUM_W'(kill_inc);

    always_comb begin
        stall_d = stall_q;
        kill_d  = kill_q;
        if (stall_ev && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (kill_sum[SUM_W-1]) begin
            kill_d = '1;
        end else begin
            kill_d = kill_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            kill_q  <= '0;
        end else begin
            stall_q <= stall_d;
            kill_q  <= kill_d;
        end
    end

    assign stall_cnt = stall_q;
    assign kill_cnt  = kill_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; covers perf counters when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [DATA_W-1:0] BUBBLE = 32'h0000_0013;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  kill_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt (stall_cnt)
        , .kill_cnt  (kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned       n_checks = 0;
    int unsigned       n_errors = 0;
    logic [DATA_W-1:0] sb_q[$];
    int unsigned       stall_m = 0;
    int unsigned       kill_m  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against scoreboard occupancy and head entry.
    task automatic check_outputs();
        logic [DATA_W-1:0] head;
        head = (sb_q.size() > 0) ? sb_q[0] : BUBBLE;
        check("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
        check("in_ready",  64'(in_ready),  64'(sb_q.size() < 2));
        check("out_data",  64'(out_data),  64'(head));
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        check("kill_cnt",  64'(kill_cnt),  64'(kill_m));
`endif
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // One clock: drive at negedge, check the state left by the previous edge, advance the model.
    task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        int unsigned sz;
        logic        acc;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs();
        sz  = sb_q.size();
        acc = iv && (sz < 2) && !fl;
        if (sz > 0 && ordy) void'(sb_q.pop_front());
        if (sz > 0 && !ordy) stall_m = sat(stall_m + 1);
        if (fl) begin
            kill_m = sat(kill_m + sb_q.size());
            sb_q.delete();
        end
        if (acc) sb_q.push_back(d);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        sb_q.delete();
        cycle(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;

        // Streaming at full throughput
        cycle(1'b1, 32'h11, 1'b1, 1'b0);
        cycle(1'b1, 32'h22, 1'b1, 1'b0);
        cycle(1'b1, 32'h33, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure into skid, then drain; 0xCC offered while in_ready=0 must be ignored
        cycle(1'b1, 32'hA0, 1'b1, 1'b0);
        cycle(1'b1, 32'hB0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 32'hCC, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush in SKID with a bundle offered
        cycle(1'b1, 32'hA0, 1'b1, 1'b0);
        cycle(1'b1, 32'hB0, 1'b0, 1'b0);
        cycle(1'b1, 32'hC0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("kill_after_skid_flush", 64'(kill_cnt), 64'd2);
`endif
        // Flush in FULL while downstream consumes, and flush while EMPTY
        cycle(1'b1, 32'hD0, 1'b1, 1'b0);
        cycle(1'b1, 32'hE0, 1'b1, 1'b1);
        cycle(1'b1, 32'hF0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Async reset in SKID, between edges
        cycle(1'b1, 32'hA0, 1'b1, 1'b0);
        cycle(1'b1, 32'hB0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'(BUBBLE));
        check("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef PIPE_STAGE_PERF_EN
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_kill_cnt",  64'(kill_cnt),  64'd0);
`endif
        sb_q.delete();
        stall_m = 0;
        kill_m  = 0;
        cycle(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Long hold to saturate the stall counter
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("stall_saturated", 64'(stall_cnt), 64'(CNT_MAX));
`endif
        // Drain to empty
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline-stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single block.
- Payload is an opaque DATA_W-bit bundle, packed and unpacked by the instantiating stage.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from a downstream stage never loses an instruction.
- Adds a synchronous flush that injects a parametrised bubble (NOP) encoding.

Parameters:
DATA_W, 32, payload width in bits (1..512)
BUBBLE, {DATA_W{1'b0}}, value driven on out_data whenever out_valid=0; set per stage to the NOP control encoding
CNT_W, 16, width of the performance counters (used only with PIPE_STAGE_PERF_EN)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  upstream stage presents a valid bundle
in_ready  out  1  block can accept a bundle this cycle
in_data  in  DATA_W  upstream bundle
out_valid  out  1  out_data holds a valid bundle
out_ready  in  1  downstream stage consumes out_data this cycle
out_data  out  DATA_W  registered bundle; equals BUBBLE when out_valid=0
flush  in  1  synchronous kill of all held and incoming bundles
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_STAGE_PERF_EN only)
kill_cnt  out  CNT_W  valid bundles discarded by flush (PIPE_STAGE_PERF_EN only)

Behaviour:
- Transfers: in-transfer when in_valid & in_ready; out-transfer when out_valid & out_ready.
- Storage: main register (drives out_data directly) and skid register. All outputs come from flops; in_ready is decoded from the state register only, with no combinational path from out_ready.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=1.
  - SKID: out_valid=1, in_ready=0.
- Transitions when flush=0:
  - EMPTY + in_valid -> FULL; main <= in_data.
  - FULL + in_valid + out_ready -> FULL; main <= in_data. Full throughput, 1 bundle/cycle.
  - FULL + in_valid + !out_ready -> SKID; skid <= in_data; main holds.
  - FULL + !in_valid + out_ready -> EMPTY; main <= BUBBLE.
  - FULL + !in_valid + !out_ready -> hold.
  - SKID + out_ready -> FULL; main <= skid. in_valid is ignored because in_ready=0.
  - SKID + !out_ready -> hold.
- Latency: 1 cycle from in-transfer to out_valid when the block is EMPTY or flowing.
- Ordering: strictly FIFO.
- The main register is only loaded on the transitions listed above, so out_data stays stable while out_valid=1 and out_ready=0.
- Flush:
  - Highest priority; takes effect at the next edge from any state.
  - Next state EMPTY; main <= BUBBLE; skid contents discarded.
  - A bundle offered on in_data in the flush cycle is dropped, even though in_ready=1 in that cycle.
  - flush with out_ready=1 and out_valid=1 still counts as an out-transfer in that cycle (downstream has taken it).
- Reset:
  - Asserting reset (reset=0) at any time, including mid-SKID, immediately forces state EMPTY, out_valid=0, out_data=BUBBLE, and the skid register to BUBBLE.
  - in_ready reads 1 once in EMPTY.
  - Counters reset to 0.
  - Release is synchronous-safe: the first in-transfer is possible at the first rising edge after reset returns to 1.
- Stall semantics of the legacy registers:
  - Legacy "stall inserts NOP" maps to flush=1 for one cycle.
  - Legacy "hold" maps to out_ready=0.

Optional Feature:
PIPE_STAGE_PERF_EN
- When defined:
  - stall_cnt increments every cycle with out_valid=1 and out_ready=0.
  - kill_cnt increments by 1 for each valid bundle discarded by flush: main when not simultaneously consumed, plus skid if held. It therefore increments by 0, 1 or 2 per cycle.
  - Both counters saturate at all-ones and never wrap.
  - Both clear on reset only.
- When undefined: stall_cnt and kill_cnt ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
1. Streaming: DATA_W=32, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 with out_valid=1 each one cycle later, in_ready always 1.
2. Back-pressure / skid: FULL holding 0xA0, out_ready=0, push 0xB0 -> in_ready=0 next cycle, out_data stays 0xA0. Raise out_ready for 2 cycles -> outputs 0xA0 then 0xB0, in_ready returns to 1, nothing lost or duplicated.
3. Flush in SKID: held 0xA0/0xB0, flush=1 with in_valid=1 and in_data=0xC0 -> next cycle out_valid=0, out_data=BUBBLE (test with BUBBLE=0x00000013), 0xC0 never appears, kill_cnt=2 (perf build).
4. Async reset mid-operation: in SKID, pull reset low between clock edges -> out_valid=0 and out_data=BUBBLE before the next edge. Release, push 0x55 -> 0x55 appears after 1 cycle.
5. Perf saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
6. Drain to empty: FULL 0x77, in_valid=0, out_ready=1 -> next cycle out_valid=0, out_data=BUBBLE, state EMPTY.
